vga_scan_driver: RTL

- Scan-side counterpart of the colour mapper: generates the DrawX/DrawY pixel coordinates the mapper consumes, and takes back the mapper's combinational RGB.
- Emits registered, sync-aligned VGA outputs: hs, vs, RGB.
- Also produces frame_start and vblank, so game logic (players, bullets, power-ups, maze) updates only outside the visible region.
- Sits between the top level and the VGA pins, replacing any free-running coordinate source.

---
 rtl/vga_timing_pkg.sv | 34 +++
 rtl/vga_pipe_delay.sv | 28 ++
 rtl/vga_scan_driver.sv | 115 +++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, coordinate/colour types and derived-total helpers
// for the scan driver and its pipeline.
package vga_timing_pkg;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    localparam int unsigned COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb4_t;

    function automatic int unsigned h_total(input int unsigned vis, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return vis + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned vis, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return vis + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_pipe_delay.sv
// Enabled shift register of DEPTH stages; every stage resets asynchronously to
// RESET_VAL so the output is defined the moment reset is asserted.
module vga_pipe_delay #(
    parameter int unsigned         DEPTH     = 2,
    parameter int unsigned         WIDTH     = 14,
    parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) stage[i] <= RESET_VAL;
        end else if (en) begin
            stage[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_driver.sv
// VGA scan generator: pixel-rate divider, DrawX/DrawY counters, sync decode and a
// pixel-enabled pipeline that keeps colour and sync aligned at the pins.
module vga_scan_driver
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT    = DEF_H_FRONT,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BACK     = DEF_H_BACK,
    parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT    = DEF_V_FRONT,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BACK     = DEF_V_BACK,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned PIPE_DEPTH = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] Red_in,
    input  logic [3:0] Green_in,
    input  logic [3:0] Blue_in,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       pixel_clk_en,
    output logic       display_on,
    output logic       vblank,
    output logic       frame_start,
    output logic       hs,
    output logic       vs,
    output logic [3:0] Red,
    output logic [3:0] Green,
    output logic [3:0] Blue
);

    localparam int unsigned H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam coord_t X_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t Y_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t X_VIS    = coord_t'(H_VISIBLE);
    localparam coord_t Y_VIS    = coord_t'(V_VISIBLE);
    localparam coord_t HS_FIRST = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_LAST  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_LAST  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    localparam logic [1:0]  DIV_LAST   = 2'(CLK_DIV - 1);
    localparam int unsigned PIPE_W     = 14;
    localparam logic [13:0] PIPE_RESET = {1'b1, 1'b1, 12'h000};

    logic [1:0]  div_q;
    logic        x_last;
    logic        y_last;
    logic        hs0;
    logic        vs0;
    rgb4_t       rgb_in;
    rgb4_t       rgb_masked;
    rgb4_t       rgb_pin;
    logic [13:0] pipe_out;

    assign x_last = (DrawX == X_LAST);
    assign y_last = (DrawY == Y_LAST);

    // pixel_clk_en is registered from the divider, so the first strobe lands on
    // the CLK_DIV-th edge after reset and the counters move on the edge after it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            div_q        <= '0;
            pixel_clk_en <= 1'b0;
            frame_start  <= 1'b0;
            DrawX        <= '0;
            DrawY        <= '0;
        end else begin
            div_q        <= (div_q == DIV_LAST) ? 2'd0 : div_q + 2'd1;
            pixel_clk_en <= (div_q == DIV_LAST);
            frame_start  <= pixel_clk_en && x_last && y_last;
            if (pixel_clk_en) begin
                if (x_last) begin
                    DrawX <= '0;
                    DrawY <= y_last ? '0 : DrawY + 10'd1;
                end else begin
                    DrawX <= DrawX + 10'd1;
                end
            end
        end
    end

    assign display_on = (DrawX < X_VIS) && (DrawY < Y_VIS);
    assign vblank     = (DrawY >= Y_VIS);
    assign hs0        = !((DrawX >= HS_FIRST) && (DrawX <= HS_LAST));
    assign vs0        = !((DrawY >= VS_FIRST) && (DrawY <= VS_LAST));

    assign rgb_in     = '{r: Red_in, g: Green_in, b: Blue_in};
    assign rgb_masked = display_on ? rgb_in : '0;

    vga_pipe_delay #(
        .DEPTH     (PIPE_DEPTH),
        .WIDTH     (PIPE_W),
        .RESET_VAL (PIPE_RESET)
    ) u_pipe (
        .clk  (Clk),
        .rst  (Reset),
        .en   (pixel_clk_en),
        .din  ({hs0, vs0, rgb_masked}),
        .dout (pipe_out)
    );

    assign hs      = pipe_out[13];
    assign vs      = pipe_out[12];
    assign rgb_pin = pipe_out[11:0];
    assign Red     = rgb_pin.r;
    assign Green   = rgb_pin.g;
    assign Blue    = rgb_pin.b;

endmodule
